// File: rtl/fifo_pop_streamer.sv
// Drains a 1-cycle pop-latency FIFO read port into a skid buffer and presents a valid/ready stream (out_valid 2 cycles after the pop).
// Pops stall once buffered plus in-flight words fill the skid, so backpressure never drops a word; FIFO_POP_STREAMER_STATS_EN enables pop_count.
module fifo_pop_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int SKID_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   output logic                        fifo_pop_enable,
   input  logic                        fifo_pop_valid,
   input  logic [DATA_WIDTH-1:0]       fifo_pop_data,
   input  logic                        fifo_pop_empty,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   input  logic                        out_ready,
   output logic [$clog2(SKID_DEPTH):0] occupancy,
   output logic                        error,
   output logic [31:0]                 pop_count
);
   localparam int PTR_W = $clog2(SKID_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W:0] DEPTH = (OCC_W+1)'(SKID_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  in_flight_q, in_flight_d;
   logic                  error_q, error_d;
   logic [OCC_W:0]        pending;
   logic                  capture;
   logic                  dequeue;

   // Issue looks only at registered state, never out_ready, so a same-cycle dequeue is not credited.
   always_comb begin
      pending         = {1'b0, occ_q} + {{OCC_W{1'b0}}, in_flight_q};
      fifo_pop_enable = enable & ~fifo_pop_empty & ~reset & (pending < DEPTH);
   end

   assign out_valid = (occ_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign occupancy = occ_q;
   assign error     = error_q;

   always_comb begin
      capture     = fifo_pop_valid & in_flight_q;
      dequeue     = out_valid & out_ready;
      in_flight_d = fifo_pop_enable;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      if (capture) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (dequeue) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({capture, dequeue})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      // Both a spurious return and a missing return are sticky faults.
      error_d = error_q | (fifo_pop_valid ^ in_flight_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         in_flight_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         in_flight_q <= in_flight_d;
         error_q     <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         mem_q[wr_ptr_q] <= fifo_pop_data;
      end
   end

`ifdef FIFO_POP_STREAMER_STATS_EN
   logic [31:0] pop_count_q, pop_count_d;

   always_comb begin
      pop_count_d = pop_count_q;
      if (capture && (pop_count_q != 32'hFFFF_FFFF)) begin
         pop_count_d = pop_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pop_count_q <= '0;
      end else begin
         pop_count_q <= pop_count_d;
      end
   end

   assign pop_count = pop_count_q;
`else
   assign pop_count = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Bench for fifo_pop_streamer: behavioural 1-cycle-latency FIFO, cycle table for the basic stream, scoreboard for ordering.
module tb_fifo_pop_streamer;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_pop_enable;
   logic          fifo_pop_valid;
   logic [DW-1:0] fifo_pop_data;
   logic          fifo_pop_empty;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [2:0]    occupancy;
   logic          error;
   logic [31:0]   pop_count;

   fifo_pop_streamer #(.DATA_WIDTH(DW), .SKID_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_pop_enable(fifo_pop_enable), .fifo_pop_valid(fifo_pop_valid),
      .fifo_pop_data(fifo_pop_data), .fifo_pop_empty(fifo_pop_empty),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy), .error(error), .pop_count(pop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          en;
      logic          rdy;
      logic          pop;
      logic          vld;
      logic [DW-1:0] dat;
      logic [2:0]    occ;
   } vec_t;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   int            n_chk = 0;
   int            n_fail = 0;
   int            pops, delivered, cyc, first_del, last_del;
   logic          lose = 1'b0;
   logic          s_pop, s_vld, s_err;
   logic [DW-1:0] s_dat;
   logic [2:0]    s_occ;
   logic [31:0]   s_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Samples mid-cycle, scores deliveries, then advances one edge and plays the FIFO read port.
   task automatic tick();
      logic          pe;
      logic [DW-1:0] e;
      #3;
      s_pop = fifo_pop_enable; s_vld = out_valid; s_dat = out_data;
      s_occ = occupancy; s_err = error; s_cnt = pop_count;
      pe = fifo_pop_enable;
      if (fifo_pop_enable) pops++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(out_data), 64'(e));
         end
         if (delivered == 0) first_del = cyc;
         last_del = cyc;
         delivered++;
      end
      @(posedge clk);
      #1;
      if (pe && lose) begin
         fifo_pop_valid = 1'b0;
         void'(fq.pop_front());
         void'(exp_q.pop_front());
      end else if (pe) begin
         fifo_pop_valid = 1'b1;
         fifo_pop_data  = fq.pop_front();
      end else begin
         fifo_pop_valid = 1'b0;
         fifo_pop_data  = $urandom;
      end
      fifo_pop_empty = (fq.size() == 0);
      cyc++;
   endtask

   task automatic load(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         fq.push_back(base + DW'(i));
         exp_q.push_back(base + DW'(i));
      end
      fifo_pop_empty = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
      fq.delete();
      exp_q.delete();
      fifo_pop_empty = 1'b1;
   endtask

   task automatic drain(input int want, input int budget);
      for (int i = 0; i < budget && delivered < want; i++) tick();
   endtask

   vec_t tbl[6];
   logic [31:0] exp_cnt3, exp_cnt15;

   initial begin
`ifdef FIFO_POP_STREAMER_STATS_EN
      exp_cnt3 = 32'd3; exp_cnt15 = 32'd15;
`else
      exp_cnt3 = 32'd0; exp_cnt15 = 32'd0;
`endif
      //          en    rdy   pop   vld   dat           occ
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA0A0_0000, 3'd1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA0A0_0001, 3'd1};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA0A0_0002, 3'd1};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};

      pops = 0; delivered = 0; cyc = 0; first_del = 0; last_del = 0;
      enable = 1'b0; out_ready = 1'b0; fifo_pop_valid = 1'b0;
      fifo_pop_data = '0; fifo_pop_empty = 1'b1; reset = 1'b1;

      // 1: reset with random inputs, pops requested but suppressed
      for (int i = 0; i < 3; i++) begin
         enable = 1'b1; fifo_pop_empty = 1'b0;
         fifo_pop_valid = 1'($urandom); fifo_pop_data = $urandom;
         out_ready = 1'($urandom);
         #3;
         chk("reset_pop_enable", 64'(fifo_pop_enable), 64'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0; enable = 1'b0; fifo_pop_empty = 1'b1;
      fifo_pop_valid = 1'b0; out_ready = 1'b0;
      tick();
      chk("reset_out_valid", 64'(s_vld), 64'd0);
      chk("reset_occupancy", 64'(s_occ), 64'd0);
      chk("reset_error", 64'(s_err), 64'd0);
      chk("reset_pop_count", 64'(s_cnt), 64'd0);

      // 2: A,B,C streamed with the cycle table
      delivered = 0;
      load(3, 32'hA0A0_0000);
      for (int i = 0; i < 6; i++) begin
         enable = tbl[i].en; out_ready = tbl[i].rdy;
         tick();
         chk($sformatf("tbl%0d_pop", i), 64'(s_pop), 64'(tbl[i].pop));
         chk($sformatf("tbl%0d_vld", i), 64'(s_vld), 64'(tbl[i].vld));
         chk($sformatf("tbl%0d_occ", i), 64'(s_occ), 64'(tbl[i].occ));
         if (tbl[i].vld) chk($sformatf("tbl%0d_dat", i), 64'(s_dat), 64'(tbl[i].dat));
      end
      chk("abc_error", 64'(s_err), 64'd0);
      chk("abc_pop_count", 64'(s_cnt), 64'(exp_cnt3));

      // 3: backpressure fills the skid, then 10 words drain in order
      out_ready = 1'b0; pops = 0; delivered = 0;
      load(10, 32'h1000_0000 + ($urandom & 32'h00FF_0000));
      enable = 1'b1;
      repeat (8) tick();
      chk("full_pops", 64'(pops), 64'd4);
      chk("full_occupancy", 64'(s_occ), 64'd4);
      chk("full_pop_enable", 64'(s_pop), 64'd0);
      out_ready = 1'b1;
      drain(10, 60);
      chk("full_delivered", 64'(delivered), 64'd10);
      chk("full_sb_empty", 64'(exp_q.size()), 64'd0);

      // 4: spurious return is flagged, discarded and sticky
      out_ready = 1'b0; delivered = 0;
      load(2, 32'h2000_0000);
      repeat (4) tick();
      enable = 1'b0;
      chk("spur_pre_occ", 64'(s_occ), 64'd2);
      fifo_pop_valid = 1'b1; fifo_pop_data = 32'hDEAD_BEEF;
      tick();
      tick();
      chk("spur_error", 64'(s_err), 64'd1);
      chk("spur_occ", 64'(s_occ), 64'd2);
      repeat (20) tick();
      chk("spur_error_held", 64'(s_err), 64'd1);
      chk("spur_occ_held", 64'(s_occ), 64'd2);
      out_ready = 1'b1;
      drain(2, 20);
      chk("spur_delivered", 64'(delivered), 64'd2);
      chk("spur_error_after_drain", 64'(s_err), 64'd1);
      do_reset(1);
      tick();
      chk("spur_error_cleared", 64'(s_err), 64'd0);

      // lost word: a pop with no returned word
      load(1, 32'h3000_0000);
      lose = 1'b1; enable = 1'b1;
      repeat (2) tick();
      lose = 1'b0;
      tick();
      chk("lost_error", 64'(s_err), 64'd1);
      chk("lost_occ", 64'(s_occ), 64'd0);
      do_reset(1);

      // 5: reset in the cycle the popped word returns
      load(3, 32'h4000_0000);
      enable = 1'b1; out_ready = 1'b1;
      tick();
      chk("rst_pop_issued", 64'(s_pop), 64'd1);
      do_reset(1);
      tick();
      chk("rst_occ", 64'(s_occ), 64'd0);
      chk("rst_error", 64'(s_err), 64'd0);
      chk("rst_out_valid", 64'(s_vld), 64'd0);
      tick();
      chk("rst_error_later", 64'(s_err), 64'd0);

      // 6: enable dropped right after a pop; the in-flight word still arrives
      pops = 0; delivered = 0;
      load(3, 32'h5000_0000);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      repeat (6) tick();
      chk("en_pops", 64'(pops), 64'd1);
      chk("en_delivered", 64'(delivered), 64'd1);
      chk("en_pop_enable_low", 64'(s_pop), 64'd0);
      chk("en_occ", 64'(s_occ), 64'd0);
      enable = 1'b1;
      drain(3, 20);
      chk("en_delivered_all", 64'(delivered), 64'd3);
      chk("en_error", 64'(s_err), 64'd0);

      // sustained stream at one word per cycle
      delivered = 0;
      load(12, 32'h6000_0000);
      drain(12, 40);
      chk("tp_delivered", 64'(delivered), 64'd12);
      chk("tp_back_to_back", 64'(last_del - first_del), 64'd11);
      repeat (3) tick();
      chk("tp_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("tp_error", 64'(s_err), 64'd0);
      chk("tp_pop_count", 64'(s_cnt), 64'(exp_cnt15));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_pop_streamer.md
Name: fifo_pop_streamer

Overview:
- Read-side consumer for a non-showahead FIFO read port that has a 1-cycle pop latency: pop request in cycle t, valid/data returned in cycle t+1.
- Issues pops, captures returned words in a small skid buffer and presents them as a valid/ready stream to downstream logic.
- Sits in the consuming clock domain, directly after a dual-clock FIFO channel, so downstream backpressure never loses a word.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and stream data.
- SKID_DEPTH, 4, skid buffer entries; power of two, >=2. Full throughput requires >=3.

Ports:
- clk  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits issuing new pops.
- fifo_pop_enable  output  1  pop request to FIFO read port.
- fifo_pop_valid  input  1  FIFO returns a word; arrives 1 cycle after fifo_pop_enable.
- fifo_pop_data  input  DATA_WIDTH  returned word.
- fifo_pop_empty  input  1  FIFO read-side empty flag.
- out_valid  output  1  stream word available.
- out_data  output  DATA_WIDTH  stream word.
- out_ready  input  1  downstream accepts the word.
- occupancy  output  $clog2(SKID_DEPTH)+1  words held in the skid buffer.
- error  output  1  sticky protocol-violation flag.
- pop_count  output  32  words popped; see Optional Feature.

Behaviour:
- State:
  - skid buffer: circular, wr_ptr/rd_ptr of $clog2(SKID_DEPTH) bits, wrapping modulo SKID_DEPTH.
  - occ counter: 0..SKID_DEPTH.
  - in_flight: register, = fifo_pop_enable of the previous cycle.
- Issue rule (combinational): fifo_pop_enable = enable & ~fifo_pop_empty & ~reset & (occ + in_flight < SKID_DEPTH).
  - No combinational path from out_ready to fifo_pop_enable.
  - The rule is conservative: it ignores a dequeue in the same cycle.
- Capture:
  - When fifo_pop_valid & in_flight, write fifo_pop_data at wr_ptr and advance wr_ptr.
  - The issue rule guarantees space for the write.
- Dequeue:
  - out_valid = (occ != 0); out_data = entry[rd_ptr], read from registers.
  - On out_valid & out_ready, advance rd_ptr.
- occ update: +1 on capture, -1 on dequeue, unchanged when both happen in the same cycle.
- Latency: FIFO non-empty at cycle t, with enable and space, gives fifo_pop_enable in t, capture at end of t+1, out_valid in t+2.
- Throughput: 1 word/cycle sustained with SKID_DEPTH>=3 and out_ready held high.
- Order is strictly preserved.
- Error conditions (error is set at the next edge and held until reset):
  - fifo_pop_valid=1 while in_flight=0: spurious word, which is discarded.
  - fifo_pop_valid=0 while in_flight=1: lost word.
- enable=0: no new pops are issued. A word already in flight is still captured, and draining continues.
- Full: occ + in_flight == SKID_DEPTH blocks issue. Issue resumes the cycle after a dequeue lowers occ.
- Empty: fifo_pop_empty=1 blocks issue. out_valid stays high while occ>0.
- Reset (synchronous, wins over every other event):
  - Values at the next edge: occ=0, both pointers 0, in_flight=0, error=0, pop_count=0, out_valid=0, fifo_pop_enable=0.
  - fifo_pop_valid is ignored during the reset cycle. A word in flight at reset is dropped without flagging error.
  - Buffer contents are not cleared (don't-care).

Optional Feature:
- Macro: FIFO_POP_STREAMER_STATS_EN.
- Defined: pop_count increments on each capture, saturates at 32'hFFFF_FFFF, and is cleared by reset.
- Undefined: pop_count is tied to 0 and the counter logic is absent. The port list is identical in both builds.

Test Plan:
1. Reset held 3 cycles with random inputs -> out_valid=0, fifo_pop_enable=0, occupancy=0, error=0, pop_count=0.
2. FIFO model preloaded with A,B,C, enable=1, out_ready=1 -> fifo_pop_enable in cycles 0,1,2; out_valid with A,B,C in cycles 2,3,4; error=0; pop_count=3 (STATS_EN).
3. FIFO holds 10 words, out_ready=0 -> exactly 4 pops, occupancy=4, then fifo_pop_enable=0. Raise out_ready -> all 10 words delivered in order, no loss.
4. Assert fifo_pop_valid for 1 cycle with no pop outstanding -> error=1 the next cycle, still 1 after 20 cycles, occupancy unchanged, cleared only by reset.
5. Reset asserted in the cycle after a pop issue (valid arrives during reset) -> after reset: occupancy=0, error=0, out_valid=0.
6. Drop enable in the same cycle as a pop -> no further pops, the in-flight word is captured and delivered, fifo_pop_enable stays 0 until enable returns.
